// File: rtl/id_stage_hazard_pipe_if.sv
// Bundle of decode-stage signals between IF/ID, the ID stage, EX and WB.
// Handshake: IF/ID->ID transfers when valid_i && ready_o at posedge; ID/EX->EX transfers when valid_o && ready_i.
interface id_stage_hazard_pipe_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int CTRL_W = 12
);
    localparam int AW = $clog2(NREGS);

    logic              valid_i;
    logic              ready_o;
    logic [AW-1:0]     rs1_i;
    logic [AW-1:0]     rs2_i;
    logic [AW-1:0]     rd_i;
    logic              load_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   pcPlus4_i;
    logic              wb_we_i;
    logic [AW-1:0]     wb_rd_i;
    logic [XLEN-1:0]   wb_data_i;
    logic              ready_i;
    logic              flush_i;
    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic              load_o;
    logic [AW-1:0]     rs1_o;
    logic [AW-1:0]     rs2_o;
    logic [AW-1:0]     rd_o;
    logic [XLEN-1:0]   rs1data_o;
    logic [XLEN-1:0]   rs2data_o;
    logic [XLEN-1:0]   imm_o;
    logic [XLEN-1:0]   pc_o;
    logic [XLEN-1:0]   pcPlus4_o;
    logic [XLEN-1:0]   a0_o;

    modport master (
        output valid_i, rs1_i, rs2_i, rd_i, load_i, ctrl_i, imm_i, pc_i, pcPlus4_i,
        output wb_we_i, wb_rd_i, wb_data_i, ready_i, flush_i,
        input  ready_o, valid_o, ctrl_o, load_o, rs1_o, rs2_o, rd_o,
        input  rs1data_o, rs2data_o, imm_o, pc_o, pcPlus4_o, a0_o
    );

    modport slave (
        input  valid_i, rs1_i, rs2_i, rd_i, load_i, ctrl_i, imm_i, pc_i, pcPlus4_i,
        input  wb_we_i, wb_rd_i, wb_data_i, ready_i, flush_i,
        output ready_o, valid_o, ctrl_o, load_o, rs1_o, rs2_o, rd_o,
        output rs1data_o, rs2data_o, imm_o, pc_o, pcPlus4_o, a0_o
    );
endinterface

// File: rtl/id_stage_hazard_pipe.sv
// Decode stage: register file with WB write-through, load-use bubble insertion,
// and the ID/EX pipeline register with stall/hold and branch flush.
module id_stage_hazard_pipe #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int CTRL_W = 12
) (
    input logic                  clk_i,
    input logic                  rstn_i,
    id_stage_hazard_pipe_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] A0_IDX = AW'(10);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            advance;
    logic            hazard;
    logic            kill;
    logic            wb_write;

    assign wb_write = bus.wb_we_i && (bus.wb_rd_i != '0);

    // x0 is never written, so the plain array read already returns zero for it.
    assign rd1 = (wb_write && bus.wb_rd_i == bus.rs1_i) ? bus.wb_data_i : regs[bus.rs1_i];
    assign rd2 = (wb_write && bus.wb_rd_i == bus.rs2_i) ? bus.wb_data_i : regs[bus.rs2_i];

    assign advance = bus.ready_i | ~bus.valid_o;
    assign hazard  = bus.valid_i & bus.valid_o & bus.load_o & (bus.rd_o != '0) &
                     ((bus.rd_o == bus.rs1_i) | (bus.rd_o == bus.rs2_i));
    assign kill    = bus.flush_i | hazard;

    assign bus.ready_o = bus.flush_i | (advance & ~hazard);
    assign bus.a0_o    = regs[A0_IDX];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            bus.valid_o   <= 1'b0;
            bus.ctrl_o    <= '0;
            bus.load_o    <= 1'b0;
            bus.rs1_o     <= '0;
            bus.rs2_o     <= '0;
            bus.rd_o      <= '0;
            bus.rs1data_o <= '0;
            bus.rs2data_o <= '0;
            bus.imm_o     <= '0;
            bus.pc_o      <= '0;
            bus.pcPlus4_o <= '0;
        end else begin
            if (wb_write) regs[bus.wb_rd_i] <= bus.wb_data_i;

            // A flush overrides a downstream stall; bubbles still capture the data fields.
            if (bus.flush_i || advance) begin
                bus.valid_o   <= bus.valid_i & ~kill;
                bus.ctrl_o    <= kill ? '0 : bus.ctrl_i;
                bus.load_o    <= bus.load_i & ~kill;
                bus.rd_o      <= kill ? '0 : bus.rd_i;
                bus.rs1_o     <= bus.rs1_i;
                bus.rs2_o     <= bus.rs2_i;
                bus.rs1data_o <= rd1;
                bus.rs2data_o <= rd2;
                bus.imm_o     <= bus.imm_i;
                bus.pc_o      <= bus.pc_i;
                bus.pcPlus4_o <= bus.pcPlus4_i;
            end else begin
                // Held operands pick up WB results so EX never sees a stale value.
                if (wb_write && bus.wb_rd_i == bus.rs1_o) bus.rs1data_o <= bus.wb_data_i;
                if (wb_write && bus.wb_rd_i == bus.rs2_o) bus.rs2data_o <= bus.wb_data_i;
            end
        end
    end
endmodule
